// File: rtl/fir_sequencer.sv
// fir_sequencer: control and MAC engine for a 4-tap FIR filter.
// It loads four coefficients through coefficient_num, takes samples on the
// rising edge of data_ready, and publishes a Q0.16-scaled result with
// saturation. One sample can wait in a pending slot while the engine is busy.
module fir_sequencer #(
  parameter int NTAPS = 4,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          data_ready,
  input  logic [DW-1:0] sample_data,
  input  logic          new_coefficient_set,
  input  logic [DW-1:0] fir_coefficient,
  output logic [1:0]    coefficient_num,
  output logic          clear_coeff,
  output logic          modwait,
  output logic [DW-1:0] fir_out,
  output logic          err
);

  localparam int AW = 2*DW + 2;

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_LOAD0    = 4'd1;
  localparam logic [3:0] S_LOAD3    = 4'd4;
  localparam logic [3:0] S_LOAD_ACK = 4'd5;
  localparam logic [3:0] S_MAC0     = 4'd6;
  localparam logic [3:0] S_MAC3     = 4'd9;
  localparam logic [3:0] S_DONE     = 4'd10;

  logic [3:0]    state_q, state_d;
  logic [DW-1:0] x_q [NTAPS];
  logic [DW-1:0] x_d [NTAPS];
  logic [DW-1:0] c_q [NTAPS];
  logic [DW-1:0] c_d [NTAPS];
  logic          coeff_valid_q, coeff_valid_d;
  logic          pend_q, pend_d;
  logic [DW-1:0] pend_val_q, pend_val_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [DW-1:0] fir_out_q, fir_out_d;
  logic          err_q, err_d;
  logic          data_ready_q, data_ready_d;

  logic          sample_evt_s;
  logic          consumed_s;
  logic          start_s;
  logic [DW-1:0] start_val_s;
  logic          err_set_s;
  logic          err_clr_s;
  logic [3:0]    load_off_s;
  logic [3:0]    mac_off_s;
  logic [2*DW-1:0] prod_s;

  assign sample_evt_s = data_ready & ~data_ready_q;
  assign load_off_s   = state_q - S_LOAD0;
  assign mac_off_s    = state_q - S_MAC0;

  // Outputs are pure decodes of registered state; coefficient_num must be
  // valid in the same cycle as each LOADk state.
  assign coefficient_num = ((state_q >= S_LOAD0) && (state_q <= S_LOAD3)) ? load_off_s[1:0] : 2'd0;
  assign clear_coeff     = (state_q == S_LOAD_ACK);
  assign modwait         = (state_q != S_IDLE) | pend_q;
  assign fir_out         = fir_out_q;
  assign err             = err_q;

  // Next-state logic: sequencing, coefficient capture, MAC and sample admission.
  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    c_d           = c_q;
    coeff_valid_d = coeff_valid_q;
    pend_d        = pend_q;
    pend_val_d    = pend_val_q;
    acc_d         = acc_q;
    fir_out_d     = fir_out_q;
    data_ready_d  = data_ready;
    consumed_s    = 1'b0;
    start_s       = 1'b0;
    start_val_s   = sample_data;
    err_set_s     = 1'b0;
    err_clr_s     = 1'b0;
    prod_s        = {{DW{1'b0}}, c_q[mac_off_s[1:0]]} * {{DW{1'b0}}, x_q[mac_off_s[1:0]]};

    case (state_q)
      S_IDLE: begin
        // Reload beats a pending sample, which beats a fresh sample.
        if (new_coefficient_set) begin
          state_d = S_LOAD0;
        end else if (pend_q) begin
          start_s     = 1'b1;
          start_val_s = pend_val_q;
          pend_d      = 1'b0;
        end else if (sample_evt_s) begin
          consumed_s = 1'b1;
          if (coeff_valid_q) begin
            start_s = 1'b1;
          end else begin
            err_set_s = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      4'd1, 4'd2, 4'd3, 4'd4: begin
        c_d[load_off_s[1:0]] = fir_coefficient;
        state_d = (state_q == S_LOAD3) ? S_LOAD_ACK : state_q + 4'd1;
      end
      S_LOAD_ACK: begin
        coeff_valid_d = 1'b1;
        state_d       = S_IDLE;
      end
      4'd6, 4'd7, 4'd8, 4'd9: begin
        // The 34-bit accumulator cannot wrap with four 32-bit products.
        acc_d   = acc_q + {2'b00, prod_s};
        state_d = (state_q == S_MAC3) ? S_DONE : state_q + 4'd1;
      end
      S_DONE: begin
        if (acc_q[AW-1:AW-2] != 2'b00) begin
          fir_out_d = {DW{1'b1}};
          err_set_s = 1'b1;
        end else begin
          fir_out_d = acc_q[2*DW-1:DW];
        end
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Starting a computation shifts the new sample into the tap line.
    if (start_s) begin
      for (int i = NTAPS-1; i > 0; i--) begin
        x_d[i] = x_q[i-1];
      end
      x_d[0]    = start_val_s;
      acc_d     = {AW{1'b0}};
      err_clr_s = 1'b1;
      state_d   = S_MAC0;
    end else begin
      err_clr_s = 1'b0;
    end

    // A sample edge not taken directly goes to the pending slot, or is
    // dropped with an error when that slot is already occupied.
    if (sample_evt_s && !consumed_s) begin
      if (pend_q) begin
        err_set_s = 1'b1;
      end else begin
        pend_d     = 1'b1;
        pend_val_d = sample_data;
      end
    end else begin
      pend_val_d = pend_val_d;
    end

    // A fresh error in the same cycle as a start must survive the clear.
    err_d = (err_clr_s ? 1'b0 : err_q) | err_set_s;
  end

  // State registers with synchronous reset that aborts any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      coeff_valid_q <= 1'b0;
      pend_q        <= 1'b0;
      pend_val_q    <= {DW{1'b0}};
      acc_q         <= {AW{1'b0}};
      fir_out_q     <= {DW{1'b0}};
      err_q         <= 1'b0;
      data_ready_q  <= 1'b0;
      for (int i = 0; i < NTAPS; i++) begin
        x_q[i] <= {DW{1'b0}};
        c_q[i] <= {DW{1'b0}};
      end
    end else begin
      state_q       <= state_d;
      coeff_valid_q <= coeff_valid_d;
      pend_q        <= pend_d;
      pend_val_q    <= pend_val_d;
      acc_q         <= acc_d;
      fir_out_q     <= fir_out_d;
      err_q         <= err_d;
      data_ready_q  <= data_ready_d;
      for (int i = 0; i < NTAPS; i++) begin
        x_q[i] <= x_d[i];
        c_q[i] <= c_d[i];
      end
    end
  end

endmodule

// File: tb/tb_fir_sequencer.sv
// tb_fir_sequencer: randomized and directed stimulus for fir_sequencer.
// A transaction-level reference model predicts results into a scoreboard
// queue; a negedge monitor pops and compares as results come due.
module tb_fir_sequencer;

  logic        clk;
  logic        rst;
  logic        data_ready;
  logic [15:0] sample_data;
  logic        new_coefficient_set;
  logic [15:0] fir_coefficient;
  logic [1:0]  coefficient_num;
  logic        clear_coeff;
  logic        modwait;
  logic [15:0] fir_out;
  logic        err;

  // Register-file side: the coefficient selected by coefficient_num.
  logic [15:0] coef_mem [4];
  assign fir_coefficient = coef_mem[coefficient_num];

  fir_sequencer #(.NTAPS(4), .DW(16)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .data_ready          (data_ready),
    .sample_data         (sample_data),
    .new_coefficient_set (new_coefficient_set),
    .fir_coefficient     (fir_coefficient),
    .coefficient_num     (coefficient_num),
    .clear_coeff         (clear_coeff),
    .modwait             (modwait),
    .fir_out             (fir_out),
    .err                 (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: the engine is busy through edge busy_end; results are
  // due five edges after a computation starts; loads take five edges.
  typedef struct { int at_cyc; logic [15:0] fir; } res_t;
  res_t        sbq [$];
  int          cyc        = 0;
  int          busy_end   = -1;
  int          load_start = -100;
  int          pub_edge   = -1;
  bit          pub_sat    = 1'b0;
  bit          pend       = 1'b0;
  logic [15:0] pval       = 16'h0;
  bit          cvalid     = 1'b0;
  bit          m_err      = 1'b0;
  bit          prev_dr    = 1'b0;
  logic [15:0] cm   [4]   = '{16'h0, 16'h0, 16'h0, 16'h0};
  logic [15:0] taps [4]   = '{16'h0, 16'h0, 16'h0, 16'h0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic start_job(input logic [15:0] v);
    longint unsigned s;
    logic [15:0] f;
    for (int k = 3; k > 0; k--) taps[k] = taps[k-1];
    taps[0] = v;
    s = 64'd0;
    for (int k = 0; k < 4; k++) s += 64'(cm[k]) * 64'(taps[k]);
    pub_sat  = (s >= 64'h1_0000_0000);
    f        = pub_sat ? 16'hFFFF : s[31:16];
    busy_end = cyc + 5;
    pub_edge = cyc + 5;
    sbq.push_back('{cyc + 5, f});
  endtask

  task automatic model_step();
    bit evt, pend_before, consumed, eset, eclr;
    cyc++;
    if (rst) begin
      busy_end = -1; load_start = -100; pub_edge = -1; pub_sat = 1'b0;
      pend = 1'b0; cvalid = 1'b0; m_err = 1'b0; prev_dr = 1'b0;
      for (int k = 0; k < 4; k++) begin cm[k] = 16'h0; taps[k] = 16'h0; end
      sbq.delete();
      sbq.push_back('{cyc, 16'h0});
      return;
    end
    evt = data_ready && !prev_dr;
    prev_dr = data_ready;
    pend_before = pend; consumed = 1'b0; eset = 1'b0; eclr = 1'b0;
    if (cyc == pub_edge && pub_sat) eset = 1'b1;
    if (cyc > busy_end) begin
      if (new_coefficient_set) begin
        busy_end = cyc + 5; load_start = cyc; cm = coef_mem; cvalid = 1'b1;
      end else if (pend) begin
        start_job(pval); pend = 1'b0; eclr = 1'b1;
      end else if (evt) begin
        consumed = 1'b1;
        if (cvalid) begin start_job(sample_data); eclr = 1'b1; end
        else eset = 1'b1;
      end
    end
    if (evt && !consumed) begin
      if (pend_before) eset = 1'b1;
      else begin pend = 1'b1; pval = sample_data; end
    end
    m_err = (eclr ? 1'b0 : m_err) | eset;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [15:0] v, input int hi);
    sample_data = v;
    data_ready  = 1'b1;
    repeat (hi) tick();
    data_ready  = 1'b0;
    tick();
  endtask

  task automatic load_coeffs(input logic [15:0] c0, input logic [15:0] c1,
                             input logic [15:0] c2, input logic [15:0] c3);
    bit seen;
    coef_mem[0] = c0; coef_mem[1] = c1; coef_mem[2] = c2; coef_mem[3] = c3;
    new_coefficient_set = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      tick();
      if (clear_coeff) seen = 1'b1;
    end
    new_coefficient_set = 1'b0;
    chk("load_handshake", 32'(seen), 32'd1);
  endtask

  // Monitor: pops due results and checks every observable output each cycle.
  initial begin
    res_t r;
    logic [15:0] exp_fir;
    logic [1:0]  exp_num;
    int d;
    exp_fir = 16'h0;
    forever begin
      @(negedge clk);
      if (cyc >= 1) begin
        if (sbq.size() > 0 && sbq[0].at_cyc == cyc) begin
          r = sbq.pop_front();
          exp_fir = r.fir;
        end
        d = cyc - load_start;
        exp_num = (d >= 0 && d <= 3) ? d[1:0] : 2'd0;
        chk("fir_out",         32'(fir_out),         32'(exp_fir));
        chk("err",             32'(err),             32'(m_err));
        chk("modwait",         32'(modwait),         32'((cyc < busy_end) || pend));
        chk("coefficient_num", 32'(coefficient_num), 32'(exp_num));
        chk("clear_coeff",     32'(clear_coeff),     32'(d == 4));
      end
    end
  end

  // Stimulus: directed scenarios, a randomized phase, then reset mid-MAC.
  initial begin
    rst = 1'b1; data_ready = 1'b0; sample_data = 16'h0; new_coefficient_set = 1'b0;
    for (int k = 0; k < 4; k++) coef_mem[k] = 16'h0;
    idle(2);
    rst = 1'b0;
    idle(2);
    send(16'd77, 1);
    idle(3);

    load_coeffs(16'h8000, 16'h8000, 16'h8000, 16'h8000);
    idle(2);
    send(16'd100, 2); idle(7);
    send(16'd200, 2); idle(7);
    send(16'd300, 2); idle(7);
    send(16'd400, 2); idle(7);

    load_coeffs(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    for (int i = 0; i < 4; i++) begin send(16'hFFFF, 2); idle(6); end
    for (int i = 0; i < 4; i++) begin send(16'h0000, 2); idle(6); end

    load_coeffs(16'h8000, 16'h4000, 16'h2000, 16'h1000);
    idle(2);
    sample_data = 16'd1000; data_ready = 1'b1; tick();
    data_ready = 1'b0; tick();
    sample_data = 16'd2000; data_ready = 1'b1; tick();
    data_ready = 1'b0; tick();
    sample_data = 16'd3000; data_ready = 1'b1; tick();
    data_ready = 1'b0;
    idle(15);

    for (int i = 0; i < 600; i++) begin
      data_ready  = ($urandom_range(0, 3) == 0);
      sample_data = 16'($urandom);
      if (!new_coefficient_set && $urandom_range(0, 59) == 0) begin
        for (int k = 0; k < 4; k++) coef_mem[k] = 16'($urandom_range(0, 16'h5000));
        new_coefficient_set = 1'b1;
      end
      rst = ($urandom_range(0, 249) == 0);
      tick();
      if (new_coefficient_set && clear_coeff) new_coefficient_set = 1'b0;
    end
    rst = 1'b0; data_ready = 1'b0;
    for (int i = 0; i < 30 && new_coefficient_set; i++) begin
      tick();
      if (clear_coeff) new_coefficient_set = 1'b0;
    end
    new_coefficient_set = 1'b0;
    idle(12);

    load_coeffs(16'h1234, 16'h4321, 16'hA000, 16'h0F0F);
    idle(2);
    sample_data = 16'hBEEF; data_ready = 1'b1; tick();
    data_ready = 1'b0; tick();
    tick();
    rst = 1'b1; tick();
    rst = 1'b0;
    idle(2);
    send(16'd5, 1);
    idle(10);

    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
